// File: rtl/vector_cpu.sv
// vector_cpu: byte-serial loaded RV32I-subset core with combinational register/memory inspection.
// Latency: one instruction per clock in RUN; inspection outputs are combinational (zero cycles).
// Backpressure: none; instr_i is consumed one byte per clock in IDLE/LOAD and ignored otherwise.
// Optional feature: define VALU_EN to enable custom-0 packed-byte VADD.B / VSUB.B.
module vector_cpu (
   input  logic       clk_i,
   input  logic       reset,
   input  logic [7:0] instr_i,
   input  logic       DataOrReg,
   input  logic [4:0] address,
   input  logic [1:0] vout_addr,
   output logic [7:0] value_o,
   output logic       is_positive,
   output logic [2:0] easter_egg
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

   localparam logic [7:0] B_START = 8'hFE;
   localparam logic [7:0] B_RUN   = 8'hFF;
   localparam logic [6:0] IMEM_FULL = 7'd64;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
`ifdef VALU_EN
   localparam logic [6:0] OP_CUSTOM = 7'b0001011;
`endif

   state_t      state, state_nx;
   logic [6:0]  pc_word;     // PC/4; the architectural PC is pc_word*4
   logic [6:0]  count;       // number of words stored (0..64)
   logic [1:0]  byte_pos;
   logic [23:0] word_buf;    // first three bytes of the word being assembled

   logic [31:0] imem [64];
   logic [31:0] regs [32];
   logic [31:0] dmem [32];

   // Decode fields of the instruction at PC
   logic [31:0] ins;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val, imm_i;
   logic [6:0]  imm_s_lo, ld_ea, st_ea;
   logic        rd_we, mem_we;
   logic [31:0] wb_data, insp_word;
   logic        unused_ea;

   assign ins      = imem[pc_word[5:0]];
   assign opcode   = ins[6:0];
   assign rd       = ins[11:7];
   assign funct3   = ins[14:12];
   assign rs1      = ins[19:15];
   assign rs2      = ins[24:20];
   assign funct7   = ins[31:25];
   assign rs1_val  = regs[rs1];
   assign rs2_val  = regs[rs2];
   assign imm_i    = {{20{ins[31]}}, ins[31:20]};
   assign imm_s_lo = {ins[26:25], ins[11:7]};
   // Only address bits [6:2] select a data word, so a 7-bit sum is enough
   assign ld_ea    = rs1_val[6:0] + imm_i[6:0];
   assign st_ea    = rs1_val[6:0] + imm_s_lo;
   assign unused_ea = ^{ld_ea[1:0], st_ea[1:0]};

   // State register
   always_ff @(posedge clk_i) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state and status flags
   always_comb begin
      state_nx   = state;
      easter_egg = 3'b000;
      case (state)
         S_IDLE: if (instr_i == B_START) state_nx = S_LOAD;
         S_LOAD: begin
            easter_egg = 3'b001;
            if (byte_pos == 2'd0 && instr_i == B_RUN) state_nx = S_RUN;
         end
         S_RUN: begin
            easter_egg = 3'b010;
            if (pc_word == count) state_nx = S_HALT;
         end
         S_HALT: easter_egg = 3'b100;
         default: state_nx = S_IDLE;
      endcase
   end

   // Execute: compute register writeback and store enable for the current instruction
   always_comb begin
      rd_we   = 1'b0;
      wb_data = 32'd0;
      mem_we  = 1'b0;
      case (opcode)
         OP_IMM: if (funct3 == 3'b000) begin
            rd_we   = 1'b1;
            wb_data = rs1_val + imm_i;
         end
         OP_REG: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000: begin rd_we = 1'b1; wb_data = rs1_val + rs2_val; end
                  3'b100: begin rd_we = 1'b1; wb_data = rs1_val ^ rs2_val; end
                  3'b110: begin rd_we = 1'b1; wb_data = rs1_val | rs2_val; end
                  3'b111: begin rd_we = 1'b1; wb_data = rs1_val & rs2_val; end
                  default: ;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               rd_we   = 1'b1;
               wb_data = rs1_val - rs2_val;
            end
         end
         OP_LOAD: if (funct3 == 3'b010) begin
            rd_we   = 1'b1;
            wb_data = dmem[ld_ea[6:2]];
         end
         OP_STORE: if (funct3 == 3'b010) mem_we = 1'b1;
`ifdef VALU_EN
         OP_CUSTOM: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
               rd_we = 1'b1;
               // Lanes are computed separately so no carry/borrow crosses a byte boundary
               for (int l = 0; l < 4; l++) begin
                  if (funct3 == 3'b000)
                     wb_data[l*8 +: 8] = rs1_val[l*8 +: 8] + rs2_val[l*8 +: 8];
                  else
                     wb_data[l*8 +: 8] = rs1_val[l*8 +: 8] - rs2_val[l*8 +: 8];
               end
            end
         end
`endif
         default: ;
      endcase
      if (rd == 5'd0) rd_we = 1'b0;
   end

   // Loader, PC, register file and data memory updates
   always_ff @(posedge clk_i) begin
      if (!reset) begin
         pc_word  <= '0;
         count    <= '0;
         byte_pos <= '0;
         word_buf <= '0;
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
            dmem[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: if (instr_i == B_START) begin
               count    <= '0;
               byte_pos <= '0;
            end
            S_LOAD: begin
               if (byte_pos == 2'd0) begin
                  if (instr_i == B_RUN) begin
                     pc_word <= '0;
                  end else if (count == IMEM_FULL) begin
                     // memory full: wait for the run byte
                  end else if (instr_i == B_START) begin
                     count <= '0;
                  end else begin
                     word_buf <= {instr_i, word_buf[23:8]};
                     byte_pos <= 2'd1;
                  end
               end else if (byte_pos == 2'd3) begin
                  count    <= count + 7'd1;
                  byte_pos <= 2'd0;
               end else begin
                  word_buf <= {instr_i, word_buf[23:8]};
                  byte_pos <= byte_pos + 2'd1;
               end
            end
            S_RUN: if (pc_word != count) begin
               pc_word <= pc_word + 7'd1;
               if (rd_we)  regs[rd] <= wb_data;
               if (mem_we) dmem[st_ea[6:2]] <= rs2_val;
            end
            default: ;
         endcase
      end
   end

   // Instruction memory write on the fourth byte of each word
   always_ff @(posedge clk_i) begin
      if (reset && state == S_LOAD && byte_pos == 2'd3)
         imem[count[5:0]] <= {instr_i, word_buf};
   end

   // Inspection port
   always_comb begin
      insp_word   = DataOrReg ? dmem[address] : regs[address];
      value_o     = insp_word[{vout_addr, 3'b000} +: 8];
      is_positive = !insp_word[31] && (insp_word != 32'd0);
   end

endmodule

// File: tb/tb_vector_cpu.sv
// Directed bench for vector_cpu: table-driven inspection checks after a mixed ALU/memory
// program, plus hand sequences for reset, empty program, full instruction memory and
// reset during load.
module tb_vector_cpu;

   logic       clk_i = 1'b0;
   logic       reset;
   logic [7:0] instr_i;
   logic       DataOrReg;
   logic [4:0] address;
   logic [1:0] vout_addr;
   logic [7:0] value_o;
   logic       is_positive;
   logic [2:0] easter_egg;

   int checks = 0;
   int failures = 0;

   logic [31:0] prog [$];

   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_C = 7'b0001011;

   typedef struct {
      logic       dor;
      logic [4:0] addr;
      logic [1:0] lane;
      logic [7:0] val;
      logic       pos;
   } check_t;

   check_t vec [17];

   vector_cpu dut (
      .clk_i(clk_i), .reset(reset), .instr_i(instr_i), .DataOrReg(DataOrReg),
      .address(address), .vout_addr(vout_addr), .value_o(value_o),
      .is_positive(is_positive), .easter_egg(easter_egg)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      logic [11:0] im = imm[11:0];
      return {im, rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd, input logic [6:0] op);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                         input int f3, input logic [6:0] op);
      logic [11:0] im = imm[11:0];
      return {im[11:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:0], op};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      instr_i = b;
      tick();
      instr_i = 8'h00;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      instr_i = 8'h00;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic rd_word(input logic dor, input logic [4:0] a, output logic [31:0] w);
      DataOrReg = dor;
      address   = a;
      for (int l = 0; l < 4; l++) begin
         vout_addr = l[1:0];
         #1;
         w[l*8 +: 8] = value_o;
      end
   endtask

   task automatic wait_halt(input int max_cycles);
      int n = 0;
      while (easter_egg !== 3'b100 && n < max_cycles) begin
         tick();
         n++;
      end
      chk("halt_reached", {29'd0, easter_egg}, 32'h4);
   endtask

   task automatic load_run();
      send(8'hFE);
      foreach (prog[i])
         for (int b = 0; b < 4; b++) send(prog[i][b*8 +: 8]);
      send(8'hFF);
      wait_halt(200);
   endtask

   task automatic push_const(input int r, input logic [31:0] v);
      prog.push_back(enc_i(v[31:24], 0, 0, r, OP_I));
      for (int k = 2; k >= 0; k--) begin
         for (int s = 0; s < 8; s++) prog.push_back(enc_r(0, r, r, 0, r, OP_R));
         prog.push_back(enc_i(v[k*8 +: 8], r, 0, r, OP_I));
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  x9_l0, x9_l2;

      DataOrReg = 1'b0;
      address   = 5'd0;
      vout_addr = 2'd0;
      do_reset();

      // Reset state
      chk("rst_value", {24'd0, value_o}, 32'h0);
      chk("rst_pos", {31'd0, is_positive}, 32'h0);
      chk("rst_egg", {29'd0, easter_egg}, 32'h0);

      // Bytes before FE ignored, then empty program halts on first RUN cycle
      send(8'hFF);
      send(8'h13);
      chk("idle_ignore", {29'd0, easter_egg}, 32'h0);
      send(8'hFE);
      chk("load_egg", {29'd0, easter_egg}, 32'h1);
      send(8'hFF);
      chk("run_egg", {29'd0, easter_egg}, 32'h2);
      tick();
      chk("empty_halt", {29'd0, easter_egg}, 32'h4);
      rd_word(1'b0, 5'd1, w);
      chk("empty_x1", w, 32'h0);

      // ADDI x1,x0,5: two RUN cycles then HALT
      do_reset();
      send(8'hFE);
      send(8'h93); send(8'h00); send(8'h50); send(8'h00);
      send(8'hFF);
      chk("addi_run1", {29'd0, easter_egg}, 32'h2);
      tick();
      chk("addi_run2", {29'd0, easter_egg}, 32'h2);
      tick();
      chk("addi_halt", {29'd0, easter_egg}, 32'h4);
      DataOrReg = 1'b0; address = 5'd1; vout_addr = 2'd0; #1;
      chk("addi_val", {24'd0, value_o}, 32'h05);
      chk("addi_pos", {31'd0, is_positive}, 32'h1);

      // ADDI x1,x0,-1 (FF as data at byte 3); SW x1,8(x0)
      do_reset();
      prog = {};
      prog.push_back(32'hFFF00093);
      prog.push_back(32'h00102423);
      load_run();
      DataOrReg = 1'b1; address = 5'd2;
      for (int l = 0; l < 4; l++) begin
         vout_addr = l[1:0]; #1;
         chk("sw_lane", {24'd0, value_o}, 32'hFF);
      end
      chk("sw_pos", {31'd0, is_positive}, 32'h0);

      // Reset mid-load aborts; new program only; x0 ignores writes
      do_reset();
      send(8'hFE);
      send(8'h93); send(8'h00);
      do_reset();
      chk("midload_egg", {29'd0, easter_egg}, 32'h0);
      prog = {};
      prog.push_back(enc_i(7, 0, 0, 0, OP_I));
      prog.push_back(enc_i(2, 0, 0, 2, OP_I));
      load_run();
      rd_word(1'b0, 5'd0, w); chk("midload_x0", w, 32'h0);
      rd_word(1'b0, 5'd2, w); chk("midload_x2", w, 32'h2);
      rd_word(1'b0, 5'd1, w); chk("midload_x1", w, 32'h0);
      rd_word(1'b1, 5'd2, w); chk("midload_mem2", w, 32'h0);

      // ALU / memory program checked against a table
      do_reset();
      prog = {};
      prog.push_back(enc_i(291, 0, 0, 1, OP_I));          // x1 = 0x123
      prog.push_back(enc_i(-3, 0, 0, 2, OP_I));           // x2 = -3
      prog.push_back(enc_r(0, 2, 1, 0, 3, OP_R));         // x3 = 0x120
      prog.push_back(enc_r(32, 1, 2, 0, 4, OP_R));        // x4 = x2-x1 = FFFFFEDA
      prog.push_back(enc_r(0, 2, 1, 4, 5, OP_R));         // x5 = FFFFFEDE
      prog.push_back(enc_r(0, 2, 1, 6, 6, OP_R));         // x6 = FFFFFFFF
      prog.push_back(enc_r(0, 2, 1, 7, 7, OP_R));         // x7 = 00000121
      prog.push_back(enc_s(-4, 4, 1, 2, OP_S));           // mem[(0x11F>>2)&31 = 7] = x4
      prog.push_back(enc_i(28, 0, 2, 8, OP_L));           // x8 = mem[7]
      prog.push_back(enc_i(7, 0, 0, 0, OP_I));            // x0 stays 0
      prog.push_back(32'h0000007F);                       // NOP
      prog.push_back(enc_r(0, 2, 1, 0, 9, OP_C));         // VADD.B x9
      load_run();
`ifdef VALU_EN
      x9_l0 = 8'h20; x9_l2 = 8'hFF;                       // 0xFFFF0020
`else
      x9_l0 = 8'h00; x9_l2 = 8'h00;
`endif
      vec[0]  = '{1'b0, 5'd3, 2'd0, 8'h20, 1'b1};
      vec[1]  = '{1'b0, 5'd3, 2'd1, 8'h01, 1'b1};
      vec[2]  = '{1'b0, 5'd4, 2'd0, 8'hDA, 1'b0};
      vec[3]  = '{1'b0, 5'd4, 2'd1, 8'hFE, 1'b0};
      vec[4]  = '{1'b0, 5'd4, 2'd3, 8'hFF, 1'b0};
      vec[5]  = '{1'b0, 5'd5, 2'd0, 8'hDE, 1'b0};
      vec[6]  = '{1'b0, 5'd5, 2'd1, 8'hFE, 1'b0};
      vec[7]  = '{1'b0, 5'd6, 2'd2, 8'hFF, 1'b0};
      vec[8]  = '{1'b0, 5'd7, 2'd0, 8'h21, 1'b1};
      vec[9]  = '{1'b0, 5'd7, 2'd1, 8'h01, 1'b1};
      vec[10] = '{1'b1, 5'd7, 2'd0, 8'hDA, 1'b0};
      vec[11] = '{1'b1, 5'd7, 2'd2, 8'hFF, 1'b0};
      vec[12] = '{1'b0, 5'd8, 2'd0, 8'hDA, 1'b0};
      vec[13] = '{1'b0, 5'd0, 2'd0, 8'h00, 1'b0};
      vec[14] = '{1'b0, 5'd9, 2'd0, x9_l0, 1'b0};
      vec[15] = '{1'b0, 5'd9, 2'd2, x9_l2, 1'b0};
      vec[16] = '{1'b1, 5'd0, 2'd0, 8'h00, 1'b0};
      for (int i = 0; i < 17; i++) begin
         DataOrReg = vec[i].dor;
         address   = vec[i].addr;
         vout_addr = vec[i].lane;
         #1;
         chk($sformatf("tbl%0d_val", i), {24'd0, value_o}, {24'd0, vec[i].val});
         chk($sformatf("tbl%0d_pos", i), {31'd0, is_positive}, {31'd0, vec[i].pos});
      end

      // Packed-byte ops in a full 64-word program; a 65th word is dropped
      do_reset();
      prog = {};
      push_const(1, 32'h010603FC);
      push_const(2, 32'h0502F9FC);
      prog.push_back(enc_r(0, 2, 1, 0, 3, OP_C));         // VADD.B x3
      prog.push_back(enc_r(0, 2, 1, 1, 4, OP_C));         // VSUB.B x4
      while (prog.size() < 64) prog.push_back(32'h00000013);
      prog.push_back(32'h00900293);                       // ADDI x5,x0,9 (beyond capacity)
      load_run();
      rd_word(1'b0, 5'd1, w); chk("vec_x1", w, 32'h010603FC);
      rd_word(1'b0, 5'd2, w); chk("vec_x2", w, 32'h0502F9FC);
`ifdef VALU_EN
      rd_word(1'b0, 5'd3, w); chk("vadd_x3", w, 32'h0608FCF8);
      rd_word(1'b0, 5'd4, w); chk("vsub_x4", w, 32'hFC040A00);
`else
      rd_word(1'b0, 5'd3, w); chk("vadd_nop_x3", w, 32'h0);
      rd_word(1'b0, 5'd4, w); chk("vsub_nop_x4", w, 32'h0);
`endif
      rd_word(1'b0, 5'd5, w); chk("full_drop_x5", w, 32'h0);

      // HALT holds state regardless of instr_i
      send(8'hFE);
      send(8'hFF);
      chk("halt_hold_egg", {29'd0, easter_egg}, 32'h4);
      rd_word(1'b0, 5'd1, w); chk("halt_hold_x1", w, 32'h010603FC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
